// File: rtl/shift_unload.sv
// shift_unload: parallel-in, serial-out unloader.
// Takes one word of TAPE chunks through a valid/ready handshake and emits it
// one D_WIDTH chunk per beat. A one-word holding register lets the next word
// arrive while the current one is still shifting out.
module shift_unload #(
   parameter int D_WIDTH   = 8,
   parameter int TAPE      = 4,
   parameter int MSB_FIRST = 0
) (
   input  logic                      i_arst,
   input  logic                      i_clk,
   input  logic                      i_valid,
   output logic                      o_ready,
   input  logic [D_WIDTH*TAPE-1:0]   i_d,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic [D_WIDTH-1:0]        o_q,
   output logic                      o_first,
   output logic                      o_last
);

   localparam int             WW       = D_WIDTH * TAPE;
   localparam int             CW       = (TAPE > 1) ? $clog2(TAPE) : 1;
   localparam logic [CW-1:0]  LAST_CNT = CW'(TAPE - 1);

   logic [WW-1:0] s_q, s_d;        // word currently being emitted
   logic [WW-1:0] h_q, h_d;        // next word waiting behind it
   logic          s_full_q, s_full_d;
   logic          h_full_q, h_full_d;
   logic [CW-1:0] cnt_q, cnt_d;    // beat index within the current word

   logic          accept;
   logic          fire;
   logic          last_fire;
   logic [CW-1:0] sel;

   assign o_valid   = s_full_q;
   assign o_ready   = !h_full_q;
   assign o_first   = (cnt_q == '0);
   assign o_last    = (cnt_q == LAST_CNT);

   assign accept    = i_valid && o_ready;
   assign fire      = o_valid && i_ready;
   assign last_fire = fire && (cnt_q == LAST_CNT);

   // Chunk index presented on o_q: counts up, or down from the top chunk.
   assign sel = (MSB_FIRST != 0) ? (LAST_CNT - cnt_q) : cnt_q;

   // Output chunk mux selecting the active slice of S.
   always_comb begin
      o_q = '0;
      for (int i = 0; i < TAPE; i++) begin
         if (sel == CW'(i)) o_q = s_q[i*D_WIDTH +: D_WIDTH];
      end
   end

   // Next-state: refill S from H or the input when it frees, else park input in H.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      s_d      = s_q;
      h_d      = h_q;
      s_full_d = s_full_q;
      h_full_d = h_full_q;
      cnt_d    = cnt_q;

      if (!s_full_q || last_fire) begin
         cnt_d = '0;
         if (h_full_q) begin
            s_d      = h_q;
            h_full_d = 1'b0;
            s_full_d = 1'b1;
         end else if (accept) begin
            s_d      = i_d;
            s_full_d = 1'b1;
         end else begin
            s_full_d = 1'b0;
         end
      end else begin
         if (accept) begin
            h_d      = i_d;
            h_full_d = 1'b1;
         end
         if (fire) cnt_d = cnt_q + CW'(1);
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         // NOTE: the data registers are reset too, so o_q reads zero out of
         // reset instead of leftover data from a discarded word.
         s_q      <= '0;
         h_q      <= '0;
         s_full_q <= 1'b0;
         h_full_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values computed above, independent of statement order.
         s_q      <= s_d;
         h_q      <= h_d;
         s_full_q <= s_full_d;
         h_full_q <= h_full_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_shift_unload.sv
// tb_shift_unload: directed and randomized checks of shift_unload against a
// word-queue model. Three instances: LSB-first and MSB-first with TAPE=4 sharing
// one input stream, and a TAPE=1 instance with its own stream.
module tb_shift_unload;

   logic        clk;
   logic        rst;

   logic        v4, rdy4;
   logic [31:0] d4;
   logic        v1, rdy1;
   logic [7:0]  d1;

   logic        a_ready, a_valid, a_first, a_last;
   logic [7:0]  a_q;
   logic        b_ready, b_valid, b_first, b_last;
   logic [7:0]  b_q;
   logic        c_ready, c_valid, c_first, c_last;
   logic [7:0]  c_q;

   int n_vec = 0;
   int n_mis = 0;

   // Model: words resident in the block (head is being emitted) and beat position.
   logic [31:0] q4[$];
   int          pos4;
   bit          acc4;
   logic [7:0]  q1[$];
   bit          acc1;
   bit          a4, f4, a1, f1;

   logic [7:0]  lit_lsb [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [7:0]  lit_msb [4] = '{8'h44, 8'h33, 8'h22, 8'h11};

   shift_unload #(.D_WIDTH(8), .TAPE(4), .MSB_FIRST(0)) dut_lsb (
      .i_arst(rst), .i_clk(clk), .i_valid(v4), .o_ready(a_ready), .i_d(d4),
      .o_valid(a_valid), .i_ready(rdy4), .o_q(a_q), .o_first(a_first), .o_last(a_last));

   shift_unload #(.D_WIDTH(8), .TAPE(4), .MSB_FIRST(1)) dut_msb (
      .i_arst(rst), .i_clk(clk), .i_valid(v4), .o_ready(b_ready), .i_d(d4),
      .o_valid(b_valid), .i_ready(rdy4), .o_q(b_q), .o_first(b_first), .o_last(b_last));

   shift_unload #(.D_WIDTH(8), .TAPE(1), .MSB_FIRST(0)) dut_t1 (
      .i_arst(rst), .i_clk(clk), .i_valid(v1), .o_ready(c_ready), .i_d(d1),
      .o_valid(c_valid), .i_ready(rdy1), .o_q(c_q), .o_first(c_first), .o_last(c_last));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] chunk(input logic [31:0] w, input int idx);
      return w[idx*8 +: 8];
   endfunction

   // Model update: a word enters when fewer than two are resident; a beat
   // leaves on each downstream handshake; the head retires after its fourth beat.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q4.delete();
         q1.delete();
         pos4 = 0;
         acc4 = 1'b0;
         acc1 = 1'b0;
      end else begin
         a4 = v4 && (q4.size() < 2);
         f4 = (q4.size() > 0) && rdy4;
         if (f4) begin
            pos4++;
            if (pos4 == 4) begin
               void'(q4.pop_front());
               pos4 = 0;
            end
         end
         if (a4) q4.push_back(d4);
         acc4 = a4;

         a1 = v1 && (q1.size() < 2);
         f1 = (q1.size() > 0) && rdy1;
         if (f1) void'(q1.pop_front());
         if (a1) q1.push_back(d1);
         acc1 = a1;
      end
   end

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      if (rst) begin
         check("rst_a_valid", a_valid, 0);
         check("rst_a_q", a_q, 0);
         check("rst_a_first", a_first, 1);
         check("rst_a_last", a_last, 0);
         check("rst_a_ready", a_ready, 1);
         check("rst_b_q", b_q, 0);
         check("rst_c_last", c_last, 1);
         check("rst_c_ready", c_ready, 1);
      end else begin
         check("a_valid", a_valid, q4.size() > 0);
         check("a_ready", a_ready, q4.size() < 2);
         check("b_valid", b_valid, q4.size() > 0);
         check("b_ready", b_ready, q4.size() < 2);
         if (q4.size() > 0) begin
            check("a_q", a_q, chunk(q4[0], pos4));
            check("b_q", b_q, chunk(q4[0], 3 - pos4));
            check("a_first", a_first, pos4 == 0);
            check("a_last", a_last, pos4 == 3);
            check("b_first", b_first, pos4 == 0);
            check("b_last", b_last, pos4 == 3);
         end
         check("c_valid", c_valid, q1.size() > 0);
         check("c_ready", c_ready, q1.size() < 2);
         if (q1.size() > 0) begin
            check("c_q", c_q, q1[0]);
            check("c_first", c_first, 1);
            check("c_last", c_last, 1);
         end
      end
   end

   task automatic pulse_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
   endtask

   initial begin
      rst  = 1'b0;
      v4   = 1'b0; d4 = '0; rdy4 = 1'b1;
      v1   = 1'b0; d1 = '0; rdy1 = 1'b1;
      pulse_reset();

      // Single word, both chunk orders.
      @(negedge clk);
      v4 = 1'b1; d4 = 32'h4433_2211;
      @(negedge clk);
      v4 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("single_lsb_q", a_q, lit_lsb[k]);
         check("single_msb_q", b_q, lit_msb[k]);
         check("single_first", a_first, k == 0);
         check("single_last", a_last, k == 3);
         @(negedge clk);
      end
      check("single_idle", a_valid, 0);

      // Back-to-back: eight beats 0x11..0x88 with no gap.
      v4 = 1'b1; d4 = 32'h4433_2211;
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         check("b2b_valid", a_valid, 1);
         check("b2b_q", a_q, 8'h11 * (k + 1));
         if (k == 0) d4 = 32'h8877_6655;
         if (k == 1) v4 = 1'b0;
         if (k >= 1 && k <= 3) check("b2b_hfull_ready", a_ready, 0);
         @(negedge clk);
      end
      check("b2b_idle", a_valid, 0);

      // Downstream stall on the 0x22 beat.
      v4 = 1'b1; d4 = 32'h4433_2211;
      @(negedge clk);
      v4 = 1'b0;
      check("stall_q0", a_q, 8'h11);
      @(negedge clk);
      rdy4 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("stall_hold_valid", a_valid, 1);
         check("stall_hold_q", a_q, 8'h22);
         if (k == 2) rdy4 = 1'b1;
         @(negedge clk);
      end
      check("stall_q2", a_q, 8'h33);
      @(negedge clk);
      check("stall_q3", a_q, 8'h44);
      @(negedge clk);
      check("stall_idle", a_valid, 0);

      // Full: two words accepted with the sink stalled, third held off.
      rdy4 = 1'b0;
      v4 = 1'b1; d4 = 32'h0403_0201;
      @(negedge clk);
      d4 = 32'h0807_0605;
      @(negedge clk);
      d4 = 32'h0C0B_0A09;
      for (int k = 0; k < 2; k++) begin
         check("full_ready", a_ready, 0);
         check("full_q", a_q, 8'h01);
         @(negedge clk);
      end
      rdy4 = 1'b1;
      for (int k = 0; k < 12; k++) begin
         check("full_drain_valid", a_valid, 1);
         check("full_drain_q", a_q, k + 1);
         if (acc4) v4 = 1'b0;
         @(negedge clk);
      end
      check("full_idle", a_valid, 0);

      // Reset right after the 0x22 beat is shown.
      v4 = 1'b1; d4 = 32'h4433_2211;
      @(negedge clk);
      v4 = 1'b0;
      @(negedge clk);
      check("rstmid_q1", a_q, 8'h22);
      #2 rst = 1'b1;
      #1;
      check("rstmid_valid", a_valid, 0);
      check("rstmid_q", a_q, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("rstmid_no_beats", a_valid, 0);
      end

      // TAPE=1: two words, one beat each.
      v1 = 1'b1; d1 = 8'hA5;
      @(negedge clk);
      d1 = 8'h5A;
      check("t1_q0", c_q, 8'hA5);
      check("t1_first0", c_first, 1);
      check("t1_last0", c_last, 1);
      @(negedge clk);
      v1 = 1'b0;
      check("t1_q1", c_q, 8'h5A);
      check("t1_both1", {c_first, c_last}, 2'b11);
      @(negedge clk);
      check("t1_idle", c_valid, 0);

      // Randomized traffic on both streams with occasional resets.
      repeat (4000) begin
         @(negedge clk);
         if (!(v4 && !acc4)) begin
            v4 = ($urandom_range(0, 9) < 6);
            d4 = $urandom();
         end
         rdy4 = ($urandom_range(0, 9) < 7);
         if (!(v1 && !acc1)) begin
            v1 = ($urandom_range(0, 9) < 5);
            d1 = 8'($urandom());
         end
         rdy1 = ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 499) == 0) begin
            #2 rst = 1'b1;
            #1;
            check("rand_rst_valid", a_valid, 0);
            #1 rst = 1'b0;
         end
      end

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/shift_unload.md
# shift_unload

Parallel-in, serial-out unloader for the CSI datapath. It accepts one wide word of TAPE chunks, each D_WIDTH bits wide, through a valid/ready handshake. It then emits the word one chunk per beat on a narrower valid/ready stream. This is the write-side counterpart of the receive-side shift/accumulate stages: it turns packed words back into lane-width beats. A one-word holding register lets the producer hand over the next word while the current one is still shifting out, so back-to-back words stream with no idle beat.

## Interface
- D_WIDTH, default 8: width of one output chunk.
- TAPE, default 4: chunks per input word; minimum 1.
- MSB_FIRST, default 0: 0 emits chunk 0 (bits D_WIDTH-1:0) first; 1 emits the top chunk first.
- i_arst  in  1: asynchronous reset, active-high.
- i_clk  in  1: single clock; all logic runs on its rising edge.
- i_valid  in  1: input word valid.
- o_ready  out  1: block can accept an input word.
- i_d  in  D_WIDTH*TAPE: input word.
- o_valid  out  1: output chunk valid.
- i_ready  in  1: downstream accepts the chunk.
- o_q  out  D_WIDTH: current output chunk.
- o_first  out  1: o_q is the first chunk of a word (qualified by o_valid).
- o_last  out  1: o_q is the last chunk of a word (qualified by o_valid).

## Operation
- Internal state:
  - shift register S, with occupancy flag s_full;
  - holding register H, with occupancy flag h_full;
  - beat counter cnt, range 0..TAPE-1, width clog2(TAPE) with a minimum of 1.
- Transfer terms:
  - accept = i_valid && o_ready.
  - fire = o_valid && i_ready.
  - last_fire = fire && cnt == TAPE-1.
- Output terms:
  - o_valid = s_full.
  - o_ready = !h_full.
  - o_first = (cnt == 0).
  - o_last = (cnt == TAPE-1).
- o_q is chunk index cnt when MSB_FIRST=0, and chunk index TAPE-1-cnt when MSB_FIRST=1. It is taken from S by a mux or by shifting S; either implementation is acceptable if the output order is identical.
- When S becomes free (s_full=0, or last_fire):
  - If h_full: S <= H, h_full <= 0, s_full <= 1, cnt <= 0.
  - Else if accept: S <= i_d, s_full <= 1, cnt <= 0.
  - Else: s_full <= 0.
- When S stays occupied and accept: H <= i_d, h_full <= 1.
- A fire that is not last_fire: cnt <= cnt+1.
- When o_valid && !i_ready: S, cnt, o_q, o_first and o_last are held stable. This is the AXI-style rule: valid is never withdrawn.
- The input side follows the same rule: the producer must hold i_d while i_valid && !o_ready. The block never samples i_d unless accept is true.
- TAPE=1: every fire is a last_fire. o_first and o_last are both 1 whenever o_valid is 1.

## Timing
- Reset (i_arst high, asynchronous):
  - s_full=0, h_full=0, cnt=0, S=0, H=0.
  - Outputs are o_valid=0, o_q=0, o_first=1, o_last=(TAPE==1), o_ready=1.
- Reset asserted mid-word: the partial word and any held word are discarded. No residual beats appear after release.
- Latency: a word accepted at edge N into an empty block drives o_valid=1 with chunk 0 after edge N, i.e. in cycle N+1.
- Throughput with i_ready held high:
  - one chunk per cycle;
  - one word per TAPE cycles;
  - no bubble between words whenever H or the input already presents the next word when last_fire occurs.
- A word accepted on the same edge as last_fire while H is empty goes directly into S. Its first chunk follows the previous word's last chunk on the next cycle.
- o_ready is registered (derived from h_full only) and has no combinational path from i_ready or i_valid.
- Capacity is two words: S plus H. o_ready falls in the cycle after H fills. It rises in the cycle after H moves into S.

## Test plan
All scenarios use D_WIDTH=8, TAPE=4 unless noted.

- Single word, MSB_FIRST=0:
  - Stimulus: i_d=0x44332211, i_ready=1.
  - Response: o_q = 0x11, 0x22, 0x33, 0x44 on consecutive cycles; o_first on the 0x11 beat; o_last on the 0x44 beat; o_valid=0 afterwards.
- MSB_FIRST=1:
  - Stimulus: same word.
  - Response: 0x44, 0x33, 0x22, 0x11.
- Back-to-back streaming:
  - Stimulus: words 0x44332211 and 0x88776655, producer always valid, i_ready=1.
  - Response: 8 consecutive valid beats 0x11..0x88 with no gap. o_ready is low for the cycles while H is full.
- Downstream stall:
  - Stimulus: drop i_ready for 3 cycles while 0x22 is presented.
  - Response: o_q stays 0x22 with o_valid=1 for those 3 cycles. The sequence then resumes 0x33, 0x44 with no loss or duplication.
- Full condition:
  - Stimulus: i_ready=0, offer three words.
  - Response: the first two words are accepted and o_ready=0 holds the third. On release, all three words emerge in order.
- Reset mid-word, then TAPE=1:
  - Stimulus: pulse i_arst after the 0x22 beat.
  - Response: o_valid=0 and o_q=0 immediately; no further beats appear.
  - Stimulus: with TAPE=1, send words 0xA5 and 0x5A.
  - Response: one beat each; o_first=o_last=1 on both beats.
